// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction front end.
//   XLEN          default instruction width in bits
//   INSTR_BYTES   bytes per instruction word (PC is a byte address)
//   INSTR_ZERO    all-zero word; treated as a stop marker by the fetch unit
//   fetch_state_t fetch controller states
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] INSTR_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Valid/ready channel from the fetch unit to the decode stage.
//   out_valid  fetch -> decode  out_instr/out_pc carry a word
//   out_ready  decode -> fetch  decode takes the word this cycle
//   out_instr  fetch -> decode  instruction word
//   out_pc     fetch -> decode  byte address of the word
// master = fetch unit, slave = decode stage.
// ---------------------------------------------------------------------------
interface instr_fetch_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [31:0]     out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_slot_sel.sv
// ---------------------------------------------------------------------------
// instr_slot_sel
// Combinational word select from a packed instruction image.
//   i_image    packed image, slot k = bits [k*XLEN +: XLEN]
//   i_idx      slot index
//   o_word     selected word
//   o_is_zero  selected word is the all-zero stop marker
// ---------------------------------------------------------------------------
module instr_slot_sel
    import riscv_pkg::*;
#(
    parameter int NUM_INSTR = 8,
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int IDX_W     = $clog2(NUM_INSTR)
) (
    input  logic [NUM_INSTR*XLEN-1:0] i_image,
    input  logic [IDX_W-1:0]          i_idx,
    output logic [XLEN-1:0]           o_word,
    output logic                      o_is_zero
);

    always_comb begin
        o_word    = i_image[int'(i_idx)*XLEN +: XLEN];
        o_is_zero = (o_word == '0);
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Walks a packed instruction image and hands one word per cycle to decode
// over a valid/ready channel. Supports redirects and halts on a zero word or
// after the last slot is taken (no wrap-around).
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   i_instr_image     packed program, held stable while not IDLE
//   i_start           begin at slot 0 (IDLE only)
//   i_redirect_valid  jump request
//   i_redirect_idx    jump target slot
//   o_halted          fetch has stopped
//   fetch_bus         master side of the decode channel
// ---------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int NUM_INSTR = 8,
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int IDX_W     = $clog2(NUM_INSTR)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_INSTR*XLEN-1:0] i_instr_image,
    input  logic                      i_start,
    input  logic                      i_redirect_valid,
    input  logic [IDX_W-1:0]          i_redirect_idx,
    output logic                      o_halted,
    instr_fetch_if.master             fetch_bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);

    // Byte address of a slot: zero-extended index with two low zero bits.
    function automatic logic [31:0] pc_of(input logic [IDX_W-1:0] idx);
        logic [31:0] ext;
        ext            = '0;
        ext[IDX_W-1:0] = idx;
        return {ext[29:0], 2'b00};
    endfunction

    // Control state
    fetch_state_t           r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_halted;

    // Output register stage
    logic                   r_vld_p0;
    logic [XLEN-1:0]        r_instr_p0;
    logic [31:0]            r_pc_p0;

    // Next-state values
    fetch_state_t           w_state_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   w_halted_nxt;
    logic                   w_vld_nxt;
    logic [XLEN-1:0]        w_instr_nxt;
    logic [31:0]            w_pc_nxt;

    // Slot to load when the output register is empty or being drained.
    logic [IDX_W-1:0]       w_rd_idx;
    logic [XLEN-1:0]        w_rd_word;
    logic                   w_rd_zero;

    // Jump target (redirect or start) and its word.
    logic                   w_jump;
    logic [IDX_W-1:0]       w_tgt_idx;
    logic [XLEN-1:0]        w_tgt_word;
    logic                   w_tgt_zero;

    assign w_rd_idx  = r_vld_p0 ? (r_idx + 1'b1) : r_idx;
    assign w_tgt_idx = i_redirect_valid ? i_redirect_idx : '0;

    instr_slot_sel #(
        .NUM_INSTR (NUM_INSTR),
        .XLEN      (XLEN),
        .IDX_W     (IDX_W)
    ) u_rd_sel (
        .i_image   (i_instr_image),
        .i_idx     (w_rd_idx),
        .o_word    (w_rd_word),
        .o_is_zero (w_rd_zero)
    );

    instr_slot_sel #(
        .NUM_INSTR (NUM_INSTR),
        .XLEN      (XLEN),
        .IDX_W     (IDX_W)
    ) u_tgt_sel (
        .i_image   (i_instr_image),
        .i_idx     (w_tgt_idx),
        .o_word    (w_tgt_word),
        .o_is_zero (w_tgt_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_halted_nxt = r_halted;
        w_vld_nxt    = r_vld_p0;
        w_instr_nxt  = r_instr_p0;
        w_pc_nxt     = r_pc_p0;
        w_jump       = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_jump = i_redirect_valid | i_start;
            end

            FETCH: begin
                if (i_redirect_valid) begin
                    w_jump = 1'b1;
                end else if (!r_vld_p0 || fetch_bus.out_ready) begin
                    if (r_vld_p0 && (r_idx == LAST_IDX)) begin
                        // Last slot consumed: stop, never wrap to slot 0.
                        w_state_nxt  = HALT;
                        w_vld_nxt    = 1'b0;
                        w_halted_nxt = 1'b1;
                    end else if (w_rd_zero) begin
                        w_state_nxt  = HALT;
                        w_idx_nxt    = w_rd_idx;
                        w_vld_nxt    = 1'b0;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_idx_nxt    = w_rd_idx;
                        w_vld_nxt    = 1'b1;
                        w_instr_nxt  = w_rd_word;
                        w_pc_nxt     = pc_of(w_rd_idx);
                    end
                end
            end

            HALT: begin
                w_jump = i_redirect_valid;
            end

            default: begin
                w_state_nxt = IDLE;
                w_vld_nxt   = 1'b0;
            end
        endcase

        // A jump drops whatever word is presented (accepted or not) and
        // leaves one bubble cycle. The target word is preloaded so the
        // bubble shows it, but it is only issued on the following cycle.
        // A zero target halts straight away instead.
        if (w_jump) begin
            w_idx_nxt   = w_tgt_idx;
            w_vld_nxt   = 1'b0;
            w_instr_nxt = w_tgt_word;
            w_pc_nxt    = pc_of(w_tgt_idx);
            if (w_tgt_zero) begin
                w_state_nxt  = HALT;
                w_halted_nxt = 1'b1;
            end else begin
                w_state_nxt  = FETCH;
                w_halted_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_halted   <= 1'b0;
            r_vld_p0   <= 1'b0;
            r_instr_p0 <= '0;
            r_pc_p0    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_halted   <= w_halted_nxt;
            r_vld_p0   <= w_vld_nxt;
            r_instr_p0 <= w_instr_nxt;
            r_pc_p0    <= w_pc_nxt;
        end
    end

    assign fetch_bus.out_valid = r_vld_p0;
    assign fetch_bus.out_instr = r_instr_p0;
    assign fetch_bus.out_pc    = r_pc_p0;
    assign o_halted            = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch: in-order issue, back-pressure, end of
// image, redirects (pending word, same-cycle accept, from HALT), reset in
// flight and a zero word at slot 0.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int NUM_INSTR = 8;
    localparam int XLEN      = 32;
    localparam int IDX_W     = 3;

    logic                      clk;
    logic                      rst;
    logic [NUM_INSTR*XLEN-1:0] image;
    logic                      start;
    logic                      redirect_valid;
    logic [IDX_W-1:0]          redirect_idx;
    logic                      halted;

    int n_chk;
    int n_err;

    logic [31:0] prog_a [NUM_INSTR] = '{
        32'h000E8E93, 32'h001F0F13, 32'h000EAE03, 32'h000F2D83,
        32'h01DE0533, 32'h00AEA023, 32'h00000000, 32'h00000000
    };
    logic [31:0] prog_full [NUM_INSTR] = '{
        32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
        32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413
    };

    instr_fetch_if #(.XLEN(XLEN)) bus ();

    instr_fetch #(
        .NUM_INSTR (NUM_INSTR),
        .XLEN      (XLEN),
        .IDX_W     (IDX_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_instr_image    (image),
        .i_start          (start),
        .i_redirect_valid (redirect_valid),
        .i_redirect_idx   (redirect_idx),
        .o_halted         (halted),
        .fetch_bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_a();
        for (int k = 0; k < NUM_INSTR; k++) image[k*XLEN +: XLEN] = prog_a[k];
    endtask

    task automatic load_full();
        for (int k = 0; k < NUM_INSTR; k++) image[k*XLEN +: XLEN] = prog_full[k];
    endtask

    task automatic chk_word(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, ".vld"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".instr"}, 64'(bus.out_instr), 64'(instr));
        chk({tag, ".pc"}, 64'(bus.out_pc), 64'(pc));
    endtask

    // Pulse start; afterwards the first slot is visible (one bubble).
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.bubble", 64'(bus.out_valid), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk          = 0;
        n_err          = 0;
        rst            = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_idx   = '0;
        bus.out_ready  = 1'b0;
        image          = '0;
        load_a();

        // Reset values and in-order issue with halt at the zero slot.
        do_reset();
        chk("rst.vld", 64'(bus.out_valid), 64'd0);
        chk("rst.instr", 64'(bus.out_instr), 64'd0);
        chk("rst.pc", 64'(bus.out_pc), 64'd0);
        chk("rst.halted", 64'(halted), 64'd0);
        bus.out_ready = 1'b1;
        start_run();
        for (int k = 0; k < 6; k++) begin
            chk_word($sformatf("seq%0d", k), prog_a[k], 32'(k * 4));
            chk("seq.halted", 64'(halted), 64'd0);
            tick();
        end
        chk("zero.vld", 64'(bus.out_valid), 64'd0);
        chk("zero.halted", 64'(halted), 64'd1);

        // Back-pressure on slot 2 for three cycles.
        do_reset();
        start_run();
        chk_word("bp0", prog_a[0], 32'd0);
        tick();
        chk_word("bp1", prog_a[1], 32'd4);
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_word($sformatf("bp.hold%0d", c), 32'h000EAE03, 32'd8);
            tick();
        end
        chk_word("bp.after_hold", 32'h000EAE03, 32'd8);
        bus.out_ready = 1'b1;
        tick();
        chk_word("bp3", prog_a[3], 32'd12);

        // End of image: all slots non-zero, halt after slot 7, no wrap.
        load_full();
        do_reset();
        start_run();
        for (int k = 0; k < 8; k++) begin
            chk_word($sformatf("full%0d", k), prog_full[k], 32'(k * 4));
            tick();
        end
        chk("eoi.vld", 64'(bus.out_valid), 64'd0);
        chk("eoi.halted", 64'(halted), 64'd1);
        tick();
        chk("eoi.nowrap.vld", 64'(bus.out_valid), 64'd0);
        chk("eoi.nowrap.halted", 64'(halted), 64'd1);

        // Redirect while slot 3 is pending (not accepted).
        load_a();
        do_reset();
        start_run();
        tick();
        tick();
        tick();
        chk_word("rd.pend3", prog_a[3], 32'd12);
        bus.out_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_idx   = 3'd1;
        tick();
        redirect_valid = 1'b0;
        chk("rd.bubble", 64'(bus.out_valid), 64'd0);
        tick();
        chk_word("rd.target", 32'h001F0F13, 32'd4);

        // Redirect in the same cycle the current word is accepted.
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_idx   = 3'd4;
        tick();
        redirect_valid = 1'b0;
        chk("rda.bubble", 64'(bus.out_valid), 64'd0);
        tick();
        chk_word("rda.target", prog_a[4], 32'd16);
        tick();
        chk_word("rda.next", prog_a[5], 32'd20);
        tick();
        chk("rda.halted", 64'(halted), 64'd1);
        chk("rda.vld", 64'(bus.out_valid), 64'd0);

        // Redirect out of HALT to slot 0.
        redirect_valid = 1'b1;
        redirect_idx   = 3'd0;
        tick();
        redirect_valid = 1'b0;
        chk("hrd.halted", 64'(halted), 64'd0);
        chk("hrd.bubble", 64'(bus.out_valid), 64'd0);
        tick();
        chk_word("hrd.target", prog_a[0], 32'd0);

        // Reset while slot 4 is presented; stays IDLE without start.
        tick();
        tick();
        tick();
        tick();
        chk_word("rmid.slot4", prog_a[4], 32'd16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid.vld", 64'(bus.out_valid), 64'd0);
        chk("rmid.pc", 64'(bus.out_pc), 64'd0);
        chk("rmid.instr", 64'(bus.out_instr), 64'd0);
        chk("rmid.halted", 64'(halted), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rmid.idle.vld", 64'(bus.out_valid), 64'd0);
            chk("rmid.idle.halted", 64'(halted), 64'd0);
        end

        // Start from IDLE (no reset) with a zero word at slot 0.
        image[0 +: XLEN] = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z0.vld0", 64'(bus.out_valid), 64'd0);
        tick();
        chk("z0.halted", 64'(halted), 64'd1);
        chk("z0.vld1", 64'(bus.out_valid), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("z0.never", 64'(bus.out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
